// File: rtl/ni_packetizer_if.sv
// ni_packetizer_if: core request, payload stream and router flit port of the NI packetizer
interface ni_packetizer_if #(parameter int LEN_W = 4);
  logic             pkt_req;
  logic [1:0]       pkt_dest;
  logic [LEN_W-1:0] pkt_len;
  logic             pkt_ready;
  logic [7:0]       body_data;
  logic             body_valid;
  logic             body_ready;
  logic             noc_ready;
  logic             flit_valid;
  logic [7:0]       flit_out;
  logic             pkt_done;
  logic             pkt_err;
  logic             reserved_hit;
  modport master (
    output pkt_req, pkt_dest, pkt_len, body_data, body_valid, noc_ready,
    input  pkt_ready, body_ready, flit_valid, flit_out, pkt_done, pkt_err, reserved_hit
  );
  modport slave (
    input  pkt_req, pkt_dest, pkt_len, body_data, body_valid, noc_ready,
    output pkt_ready, body_ready, flit_valid, flit_out, pkt_done, pkt_err, reserved_hit
  );
endinterface

// File: rtl/ni_packetizer.sv
// ni_packetizer: turns a send request plus payload bytes into head/body/trailer flits for the router NI port
module ni_packetizer #(
  parameter int          LEN_W   = 4,
  parameter logic [5:0]  HEAD    = 6'b101111,
  parameter logic [7:0]  TRAILER = 8'hFF,
  parameter logic [7:0]  SUBST   = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        current_node,
  ni_packetizer_if.slave    b
);
  typedef enum logic [1:0] {IDLE, BODY, TAIL, DRAIN} state_t;
  state_t           state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] count;
  logic             up;
  logic             load_en;
  logic             take;
  logic             hit;
  assign load_en      = !b.flit_valid || b.noc_ready;
  // up keeps pkt_ready low while reset is held and until the first clock after release
  assign b.pkt_ready  = up && state == IDLE;
  assign b.body_ready = state == BODY && load_en;
  assign take         = b.body_valid && b.body_ready;
  assign hit          = b.body_data == TRAILER || b.body_data[7:2] == HEAD;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      len            <= '0;
      count          <= '0;
      up             <= 1'b0;
      b.flit_out     <= 8'h00;
      b.flit_valid   <= 1'b0;
      b.pkt_done     <= 1'b0;
      b.pkt_err      <= 1'b0;
      b.reserved_hit <= 1'b0;
    end else begin
      up         <= 1'b1;
      b.pkt_done <= 1'b0;
      b.pkt_err  <= 1'b0;
      if (load_en) b.flit_valid <= 1'b0;
      case (state)
        IDLE: if (b.pkt_req && b.pkt_ready) begin
          if (b.pkt_dest == current_node) b.pkt_err <= 1'b1;
          else begin
            len            <= b.pkt_len;
            count          <= '0;
            b.reserved_hit <= 1'b0;
            b.flit_out     <= {HEAD, b.pkt_dest};
            b.flit_valid   <= 1'b1;
            state          <= |b.pkt_len ? BODY : TAIL;
          end
        end
        BODY: if (take) begin
          b.flit_out   <= hit ? SUBST : b.body_data;
          b.flit_valid <= 1'b1;
          if (hit) b.reserved_hit <= 1'b1;
          count <= count + LEN_W'(1);
          if (count + LEN_W'(1) == len) state <= TAIL;
        end
        TAIL: if (load_en) begin
          b.flit_out   <= TRAILER;
          b.flit_valid <= 1'b1;
          state        <= DRAIN;
        end
        default: if (b.flit_valid && b.noc_ready) begin
          b.pkt_done <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ni_packetizer.sv
// tb_ni_packetizer: directed packets checked against a flit-queue model of the NI packet format
module tb_ni_packetizer;
  logic       clk;
  logic       rst;
  logic [1:0] node;
  int         checks;
  int         errors;
  int         cyc;
  int         head_cyc;
  int         span;
  int         br_cnt;
  logic [7:0] pay [16];
  typedef struct packed {logic [7:0] f; logic is_first; logic is_last;} ent_t;
  ent_t exp_q[$];
  logic       done_exp;
  logic       stall;
  logic [7:0] held;

  ni_packetizer_if #(.LEN_W(4)) b();
  ni_packetizer dut (.clk(clk), .rst(rst), .current_node(node), .b(b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] subst(input logic [7:0] d);
    return (d == 8'hFF || d[7:2] == 6'b101111) ? 8'h00 : d;
  endfunction

  // Every cycle: each transferred flit must be the next one the packet format predicts,
  // a stalled flit must hold, and pkt_done must follow the trailer transfer by one cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      exp_q.delete();
      done_exp = 1'b0;
      stall = 1'b0;
    end else begin
      chk("pkt_done", b.pkt_done, done_exp);
      if (stall) begin
        chk("hold_valid", b.flit_valid, 1'b1);
        chk("hold_flit", b.flit_out, held);
      end
      done_exp = 1'b0;
      stall = b.flit_valid && !b.noc_ready;
      held = b.flit_out;
      if (b.flit_valid && b.noc_ready) begin
        if (exp_q.size() == 0) chk("unexpected_flit", b.flit_out, 32'hFFFF_FFFF);
        else begin
          ent_t e;
          e = exp_q.pop_front();
          chk("flit", b.flit_out, e.f);
          if (e.is_first) head_cyc = cyc;
          if (e.is_last) begin
            done_exp = 1'b1;
            span = cyc - head_cyc;
          end
        end
      end
      if (b.body_ready) br_cnt++;
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!b.pkt_ready && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 60) chk("ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [1:0] dest, input int len, input int nfeed);
    int i = 0;
    int t = 0;
    logic hs;
    exp_q.push_back(ent_t'{f: {6'b101111, dest}, is_first: 1'b1, is_last: 1'b0});
    for (int k = 0; k < len; k++) exp_q.push_back(ent_t'{f: subst(pay[k]), is_first: 1'b0, is_last: 1'b0});
    exp_q.push_back(ent_t'{f: 8'hFF, is_first: 1'b0, is_last: 1'b1});
    wait_ready();
    b.pkt_req = 1'b1;
    b.pkt_dest = dest;
    b.pkt_len = 4'(len);
    @(posedge clk); #1;
    b.pkt_req = 1'b0;
    while (i < nfeed && t < 200) begin
      b.body_valid = 1'b1;
      b.body_data = pay[i];
      #1;
      hs = b.body_ready;
      @(posedge clk); #1;
      if (hs) i++;
      t++;
    end
    b.body_valid = 1'b0;
    if (t >= 200) chk("feed_timeout", 0, 1);
    if (nfeed == len) begin
      t = 0;
      while (!b.pkt_done && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 100) chk("done_timeout", 0, 1);
    end
  endtask

  task automatic reset_checks();
    chk("rst_flit_valid", b.flit_valid, 1'b0);
    chk("rst_flit_out", b.flit_out, 8'h00);
    chk("rst_pkt_ready", b.pkt_ready, 1'b0);
    chk("rst_body_ready", b.body_ready, 1'b0);
    chk("rst_pkt_done", b.pkt_done, 1'b0);
    chk("rst_pkt_err", b.pkt_err, 1'b0);
    chk("rst_reserved_hit", b.reserved_hit, 1'b0);
  endtask

  initial begin
    int br0;
    checks = 0; errors = 0; cyc = 0; span = -1; br_cnt = 0; head_cyc = 0;
    rst = 1'b0; node = 2'd0;
    b.pkt_req = 1'b0; b.pkt_dest = 2'd0; b.pkt_len = 4'd0;
    b.body_data = 8'h00; b.body_valid = 1'b0; b.noc_ready = 1'b1;
    #1;
    reset_checks();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", b.pkt_ready, 1'b1);

    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    send(2'd2, 3, 3);
    chk("span_len3", span, 4);
    chk("no_reserved", b.reserved_hit, 1'b0);

    fork
      send(2'd2, 3, 3);
      begin
        for (int t = 0; t < 40 && !(b.flit_valid && b.flit_out == 8'h22); t++) begin
          @(posedge clk); #1;
        end
        b.noc_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          #1;
          chk("stall_body_ready", b.body_ready, 1'b0);
          chk("stall_flit", b.flit_out, 8'h22);
          @(posedge clk); #1;
        end
        b.noc_ready = 1'b1;
      end
    join
    chk("span_stalled", span, 7);

    br0 = br_cnt;
    send(2'd1, 0, 0);
    chk("span_len0", span, 1);
    chk("len0_body_ready", br_cnt - br0, 0);

    pay[0] = 8'hFF; pay[1] = 8'hBC;
    send(2'd1, 2, 2);
    chk("reserved_set", b.reserved_hit, 1'b1);

    node = 2'd3;
    wait_ready();
    b.pkt_req = 1'b1; b.pkt_dest = 2'd3; b.pkt_len = 4'd2;
    @(posedge clk); #1;
    b.pkt_req = 1'b0;
    chk("err_pulse", b.pkt_err, 1'b1);
    chk("err_no_done", b.pkt_done, 1'b0);
    chk("err_no_flit", b.flit_valid, 1'b0);
    chk("err_ready", b.pkt_ready, 1'b1);
    chk("err_keeps_reserved", b.reserved_hit, 1'b1);
    @(posedge clk); #1;
    chk("err_one_cycle", b.pkt_err, 1'b0);
    chk("err_still_no_flit", b.flit_valid, 1'b0);

    pay[0] = 8'h7E;
    send(2'd0, 1, 1);
    chk("reserved_cleared", b.reserved_hit, 1'b0);

    node = 2'd0;
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04; pay[4] = 8'h05;
    send(2'd2, 5, 2);
    rst = 1'b0;
    #1;
    reset_checks();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    pay[0] = 8'hA1; pay[1] = 8'hA2;
    send(2'd1, 2, 2);
    chk("span_after_reset", span, 3);

    repeat (5) @(posedge clk);
    chk("model_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
